stopwatch_time_ctrl: RTL and testbench
======================================

// Module: stopwatch_time_ctrl
// PURPOSE
// - Controller and timebase sequencer for the stopwatch datapath. Sits downstream of
//   stopwatchFSM: consumes its o_ENABLE and advances a BCD MM:SS.CC time value.
// - Adds lap capture/hold and a display mux, and presents one 24-bit BCD word to the
//   display driver.
// - Owns the prescaler, the digit-carry sequencing and the lap register. The FSM keeps
//   control of run/stop.
// PARAMETERS
// - P_TICK_DIV  10  i_CLK cycles per centisecond. 10 gives 10 ms at a 1 kHz i_CLK. Must be >= 2.
// PORTS
// - i_CLK         in   1   system clock, usually 1 kHz. Sole clock domain.
// - i_RST         in   1   asynchronous, active-high reset.
// - i_ENABLE      in   1   count enable (stopwatchFSM o_ENABLE). Level-sensitive.
// - i_CLEAR       in   1   synchronous clear of time, lap and overflow. Level-sensitive.
// - i_LAP         in   1   lap button, already debounced. Acts on its rising edge.
// - o_DIGITS      out  24  BCD {M1,M0,S1,S0,C1,C0}, 4 bits each. Live time or held lap.
// - o_LAP_ACTIVE  out  1   1 while o_DIGITS shows the frozen lap value.
// - o_OVERFLOW    out  1   sticky. Set when the time wraps past 59:59.99.
// - o_CS_TICK     out  1   one-cycle pulse on each centisecond advance, for debug/bench.
// BEHAVIOUR
// - Reset (async): all outputs, counters, prescaler, lap register, edge-detect flop -> 0.
//   State -> s_LIVE.
// - Prescaler: counts 0..P_TICK_DIV-1 on each cycle with i_ENABLE=1.
//   - At terminal count it returns to 0 and raises the internal tick.
//   - With i_ENABLE=0 it holds its value (not cleared), so stop/start keeps sub-tick phase.
// - Time update on tick, registered:
//   - C0 0..9, then C1 0..9, then S0 0..9, then S1 0..5, then M0 0..9, then M1 0..5.
//   - A digit carries only when every lower digit is at its max.
//   - 59:59.99 + tick -> 00:00.00 and sets o_OVERFLOW, which holds until i_CLEAR or i_RST.
// - o_CS_TICK is high in the cycle after the tick edge, together with the updated time.
// - Latency: i_ENABLE rise to first o_CS_TICK is P_TICK_DIV cycles, starting from prescaler 0.
// - Lap FSM, two states, lap_rise = i_LAP & ~i_LAP_q:
//   - s_LIVE: o_DIGITS = live time. On lap_rise, lap_reg <= live time as held in the
//     register at that edge (pre-increment if a tick coincides); go to s_HOLD.
//   - s_HOLD: o_DIGITS = lap_reg. Counting continues underneath. On lap_rise, go to s_LIVE.
//   - o_LAP_ACTIVE = (state == s_HOLD), registered.
//   - Lap works whether i_ENABLE is 0 or 1.
// - i_CLEAR has top priority over tick and lap in the same cycle:
//   - Time, prescaler, lap_reg and o_OVERFLOW -> 0.
//   - State -> s_LIVE. o_CS_TICK = 0.
//   - While i_CLEAR is held, lap_rise is ignored, but the edge flop still tracks i_LAP.
// - o_DIGITS is registered: it reflects state and time one cycle after the causing edge.
// - Digits never hold non-BCD values. Any illegal digit value reloads 0 on the next tick.
// - Reset mid-count or mid-hold: immediate return to the reset values above. No partial carry.
// STRUCTURE
// - Shared include stopwatch_defs.vh:
//   - lap state encodings s_LIVE=1'b0, s_HOLD=1'b1
//   - digit maxima: 4'd9, and 4'd5 for the tens digits
//   - 24-bit BCD field offsets
// - One sub-module, stopwatch_bcd_digit (parameter P_MAX):
//   - inputs: clk, rst, clear, carry_in
//   - outputs: 4-bit value, carry_out = carry_in & (value == P_MAX)
//   - instantiated 6x as a ripple-enable chain
// - Prescaler, edge detect, lap FSM, lap register and output mux stay in this module.
// TESTING
// - Reset, i_ENABLE=1 for 10 cycles (P_TICK_DIV=10) -> one o_CS_TICK; o_DIGITS=24'h000001.
// - Run 100 ticks -> o_DIGITS=24'h000100. Stop 5 cycles mid-prescale, then resume ->
//   next tick arrives exactly after the remaining cycles.
// - Preload via 359999 ticks to 59:59.99 (24'h595999), then one more tick ->
//   24'h000000 and o_OVERFLOW=1. Then i_CLEAR=1 -> o_OVERFLOW=0.
// - Lap at 00:12.34 while running -> o_DIGITS frozen at 24'h001234, o_LAP_ACTIVE=1.
//   After 50 ticks, second lap_rise -> o_DIGITS=24'h001284, o_LAP_ACTIVE=0.
// - Coincident events in one cycle:
//   - i_LAP rise on the tick edge at 00:00.09 -> lap_reg=24'h000009.
//   - i_CLEAR with tick and lap together -> all zero, s_LIVE.
// - Assert i_RST asynchronously mid-hold at 24'h001234 -> outputs 0 before the next i_CLK edge.

Source files
------------

// File: rtl/stopwatch_time_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_time_ctrl_pkg
// Shared definitions for the stopwatch timebase slice:
//   - lap display state encodings
//   - digit maxima for units and tens digits
//   - nibble offsets of each digit inside the 24-bit BCD word {M1,M0,S1,S0,C1,C0}
// -----------------------------------------------------------------------------
package stopwatch_time_ctrl_pkg;

    typedef enum logic {
        s_LIVE = 1'b0,
        s_HOLD = 1'b1
    } lap_state_t;

    localparam logic [3:0] DIGIT_MAX_UNITS = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS  = 4'd5;

    localparam int OFS_C0 = 0;
    localparam int OFS_C1 = 4;
    localparam int OFS_S0 = 8;
    localparam int OFS_S1 = 12;
    localparam int OFS_M0 = 16;
    localparam int OFS_M1 = 20;

endpackage

// File: rtl/stopwatch_time_ctrl_bcd_digit.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd_digit
// One BCD digit of the time value, counting 0..P_MAX. Digits are chained as a
// ripple-enable: a digit advances only when its carry_in is high, which the
// previous stage raises only while every lower digit sits at its maximum.
// Ports:
//   clk        in   1  clock
//   rst        in   1  asynchronous active-high reset
//   clear      in   1  synchronous clear to 0 (wins over carry_in)
//   carry_in   in   1  advance enable
//   value      out  4  current digit value
//   carry_out  out  1  carry_in & (value == P_MAX)
// -----------------------------------------------------------------------------
module stopwatch_bcd_digit
    import stopwatch_time_ctrl_pkg::*;
#(
    parameter logic [3:0] P_MAX = DIGIT_MAX_UNITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       carry_in,
    output logic [3:0] value,
    output logic       carry_out
);

    // ">=" rather than "==" so a corrupted (non-BCD) value falls back to 0
    // on its next advance instead of counting through illegal codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 4'd0;
        end else if (clear) begin
            value <= 4'd0;
        end else if (carry_in) begin
            value <= (value >= P_MAX) ? 4'd0 : value + 4'd1;
        end
    end

    assign carry_out = carry_in & (value == P_MAX);

endmodule

// File: rtl/stopwatch_time_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_time_ctrl
// Timebase and display sequencer for the stopwatch. Divides i_CLK down to a
// centisecond tick while i_ENABLE is high, advances a BCD MM:SS.CC value,
// captures/holds lap times and muxes live or lap time onto o_DIGITS.
//
// Lap FSM
//   state  | meaning
//   s_LIVE | o_DIGITS shows the running time
//   s_HOLD | o_DIGITS shows the frozen lap register, time keeps counting
//
// Ports:
//   i_CLK         in   1   system clock (sole domain)
//   i_RST         in   1   asynchronous active-high reset
//   i_ENABLE      in   1   count enable, level
//   i_CLEAR       in   1   synchronous clear of time, lap and overflow, level
//   i_LAP         in   1   debounced lap button, acts on rising edge
//   o_DIGITS      out  24  BCD {M1,M0,S1,S0,C1,C0}
//   o_LAP_ACTIVE  out  1   high while the lap value is displayed
//   o_OVERFLOW    out  1   sticky wrap flag past 59:59.99
//   o_CS_TICK     out  1   one-cycle pulse alongside each time advance
// -----------------------------------------------------------------------------
module stopwatch_time_ctrl
    import stopwatch_time_ctrl_pkg::*;
#(
    parameter int P_TICK_DIV = 10
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_ENABLE,
    input  logic        i_CLEAR,
    input  logic        i_LAP,
    output logic [23:0] o_DIGITS,
    output logic        o_LAP_ACTIVE,
    output logic        o_OVERFLOW,
    output logic        o_CS_TICK
);

    localparam int            PW       = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(P_TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic          tick;
    logic [6:0]    carry;
    logic [3:0]    c0, c1, s0, s1, m0, m1;
    logic [23:0]   live_time;
    logic [23:0]   lap_reg;
    logic          lap_q;
    logic          lap_rise;
    logic          lap_load;
    lap_state_t    state_q, state_d;

    // Prescaler holds (not clears) while disabled so stop/start keeps phase.
    assign tick = i_ENABLE & (presc_q == PRESC_TC);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            presc_q <= '0;
        end else if (i_CLEAR || tick) begin
            presc_q <= '0;
        end else if (i_ENABLE) begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Digit chain; clear beats a coincident tick.
    assign carry[0] = tick & ~i_CLEAR;

    stopwatch_bcd_digit #(.P_MAX(DIGIT_MAX_UNITS)) u_c0 (
        .clk(i_CLK), .rst(i_RST), .clear(i_CLEAR), .carry_in(carry[0]), .value(c0), .carry_out(carry[1])
    );
    stopwatch_bcd_digit #(.P_MAX(DIGIT_MAX_UNITS)) u_c1 (
        .clk(i_CLK), .rst(i_RST), .clear(i_CLEAR), .carry_in(carry[1]), .value(c1), .carry_out(carry[2])
    );
    stopwatch_bcd_digit #(.P_MAX(DIGIT_MAX_UNITS)) u_s0 (
        .clk(i_CLK), .rst(i_RST), .clear(i_CLEAR), .carry_in(carry[2]), .value(s0), .carry_out(carry[3])
    );
    stopwatch_bcd_digit #(.P_MAX(DIGIT_MAX_TENS)) u_s1 (
        .clk(i_CLK), .rst(i_RST), .clear(i_CLEAR), .carry_in(carry[3]), .value(s1), .carry_out(carry[4])
    );
    stopwatch_bcd_digit #(.P_MAX(DIGIT_MAX_UNITS)) u_m0 (
        .clk(i_CLK), .rst(i_RST), .clear(i_CLEAR), .carry_in(carry[4]), .value(m0), .carry_out(carry[5])
    );
    stopwatch_bcd_digit #(.P_MAX(DIGIT_MAX_TENS)) u_m1 (
        .clk(i_CLK), .rst(i_RST), .clear(i_CLEAR), .carry_in(carry[5]), .value(m1), .carry_out(carry[6])
    );

    assign live_time[OFS_C0 +: 4] = c0;
    assign live_time[OFS_C1 +: 4] = c1;
    assign live_time[OFS_S0 +: 4] = s0;
    assign live_time[OFS_S1 +: 4] = s1;
    assign live_time[OFS_M0 +: 4] = m0;
    assign live_time[OFS_M1 +: 4] = m1;

    // carry[6] is the tick that takes 59:59.99 back to 00:00.00.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_OVERFLOW <= 1'b0;
            o_CS_TICK  <= 1'b0;
            lap_q      <= 1'b0;
        end else begin
            if (i_CLEAR) begin
                o_OVERFLOW <= 1'b0;
            end else if (carry[6]) begin
                o_OVERFLOW <= 1'b1;
            end
            o_CS_TICK <= tick & ~i_CLEAR;
            lap_q     <= i_LAP;
        end
    end

    // The edge flop keeps tracking during clear, so a button held through a
    // clear does not register as a new press afterwards.
    assign lap_rise = i_LAP & ~lap_q & ~i_CLEAR;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= s_LIVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lap_load = 1'b0;
        if (i_CLEAR) begin
            state_d = s_LIVE;
        end else if (lap_rise) begin
            case (state_q)
                s_LIVE: begin
                    state_d  = s_HOLD;
                    lap_load = 1'b1;
                end
                s_HOLD:  state_d = s_LIVE;
                default: state_d = s_LIVE;
            endcase
        end
    end

    // Captures the registered (pre-increment) time if a tick lands on the same edge.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            lap_reg <= '0;
        end else if (i_CLEAR) begin
            lap_reg <= '0;
        end else if (lap_load) begin
            lap_reg <= live_time;
        end
    end

    // Every source of the display mux is a flop, so o_DIGITS follows the
    // causing edge by one cycle with no extra pipeline stage.
    assign o_LAP_ACTIVE = (state_q == s_HOLD);
    assign o_DIGITS     = (state_q == s_HOLD) ? lap_reg : live_time;

endmodule

// File: tb/tb_stopwatch_time_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_time_ctrl;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic        lap = 1'b0;
    logic [23:0] digits;
    logic        lap_act;
    logic        ovf;
    logic        cs_tick;

    stopwatch_time_ctrl #(.P_TICK_DIV(DIV)) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_ENABLE    (en),
        .i_CLEAR     (clr),
        .i_LAP       (lap),
        .o_DIGITS    (digits),
        .o_LAP_ACTIVE(lap_act),
        .o_OVERFLOW  (ovf),
        .o_CS_TICK   (cs_tick)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [23:0] digits;
        logic        lap;
        logic        ovf;
    } tick_exp_t;

    typedef struct {
        string       name;
        logic [23:0] digits;
        logic        lap;
        logic        ovf;
        logic        cs;
    } snap_exp_t;

    tick_exp_t tick_q[$];
    snap_exp_t snap_q[$];
    event      snap_ev;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    logic [23:0] m_time   = '0;
    logic [23:0] m_lapreg = '0;
    int          m_presc  = 0;
    logic        m_hold   = 1'b0;
    logic        m_ovf    = 1'b0;
    logic        m_lapq   = 1'b0;

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        int          mx[6] = '{9, 9, 9, 5, 9, 5};
        r = t;
        for (int i = 0; i < 6; i++) begin
            if (r[i*4 +: 4] == mx[i][3:0]) begin
                r[i*4 +: 4] = 4'd0;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                break;
            end
        end
        return r;
    endfunction

    // Tick monitor: pops the next expected advance when its cycle arrives and
    // flags any pulse nobody asked for.
    always @(negedge clk) begin
        tick_exp_t t;
        if (tick_q.size() != 0 && tick_q[0].cyc == cyc) begin
            t = tick_q.pop_front();
            check("cs_tick_present", {31'b0, cs_tick}, 32'd1);
            check("tick_digits", {8'b0, digits}, {8'b0, t.digits});
            check("tick_lap_active", {31'b0, lap_act}, {31'b0, t.lap});
            check("tick_overflow", {31'b0, ovf}, {31'b0, t.ovf});
        end else if (cs_tick !== 1'b0) begin
            n_checks++;
            $display("FAIL unexpected_cs_tick: got %b at cycle %0d, want 0", cs_tick, cyc);
        end
    end

    // Snapshot monitor: hand-computed expectations pushed by the stimulus.
    always @(snap_ev) begin
        snap_exp_t s;
        while (snap_q.size() != 0) begin
            s = snap_q.pop_front();
            check({s.name, "_digits"}, {8'b0, digits}, {8'b0, s.digits});
            check({s.name, "_lap_active"}, {31'b0, lap_act}, {31'b0, s.lap});
            check({s.name, "_overflow"}, {31'b0, ovf}, {31'b0, s.ovf});
            check({s.name, "_cs_tick"}, {31'b0, cs_tick}, {31'b0, s.cs});
        end
    end

    task automatic snap(input string name, input logic [23:0] d, input logic la,
                        input logic ov, input logic cs);
        snap_exp_t s;
        #2;
        s.name = name; s.digits = d; s.lap = la; s.ovf = ov; s.cs = cs;
        snap_q.push_back(s);
        -> snap_ev;
        #1;
    endtask

    // One clock cycle of stimulus; the model predicts the following edge.
    task automatic step(input logic e, input logic c, input logic l);
        logic      rise;
        logic      tick;
        tick_exp_t t;
        @(negedge clk);
        en = e; clr = c; lap = l;
        rise   = l & ~m_lapq & ~c;
        m_lapq = l;
        if (c) begin
            m_time = '0; m_lapreg = '0; m_presc = 0; m_ovf = 1'b0; m_hold = 1'b0;
        end else begin
            tick = e && (m_presc == DIV - 1);
            if (rise) begin
                if (!m_hold) m_lapreg = m_time;
                m_hold = ~m_hold;
            end
            if (e) m_presc = tick ? 0 : m_presc + 1;
            if (tick) begin
                if (m_time == 24'h595999) begin
                    m_time = '0;
                    m_ovf  = 1'b1;
                end else begin
                    m_time = bcd_inc(m_time);
                end
                t.cyc    = cyc + 1;
                t.digits = m_hold ? m_lapreg : m_time;
                t.lap    = m_hold;
                t.ovf    = m_ovf;
                tick_q.push_back(t);
            end
        end
        @(posedge clk);
    endtask

    task automatic run_ticks(input int n, input logic l);
        int done;
        logic pre;
        done = 0;
        while (done < n) begin
            pre = (m_presc == DIV - 1);
            step(1'b1, 1'b0, l);
            if (pre) done++;
        end
    endtask

    task automatic model_reset();
        m_time = '0; m_lapreg = '0; m_presc = 0; m_hold = 1'b0; m_ovf = 1'b0; m_lapq = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        snap("reset", 24'h000000, 1'b0, 1'b0, 1'b0);

        // First tick after exactly DIV enabled cycles
        repeat (DIV) step(1'b1, 1'b0, 1'b0);
        snap("first_tick", 24'h000001, 1'b0, 1'b0, 1'b1);

        run_ticks(99, 1'b0);
        snap("hundred", 24'h000100, 1'b0, 1'b0, 1'b1);

        // Pause mid-prescale: 4 cycles in, stop 5, then the remaining 6 finish the tick
        repeat (4) step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        snap("paused", 24'h000100, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        snap("resume_pre", 24'h000100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        snap("resume_tick", 24'h000101, 1'b0, 1'b0, 1'b1);

        // Lap while running at 00:12.34, hold 50 ticks, release at 00:12.84
        run_ticks(1133, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        snap("lap_hold", 24'h001234, 1'b1, 1'b0, 1'b0);
        run_ticks(50, 1'b1);
        snap("hold_frozen", 24'h001234, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        snap("lap_release", 24'h001284, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 1'b0);
        snap("clear", 24'h000000, 1'b0, 1'b0, 1'b0);

        // Lap rise on the same edge as the tick out of 00:00.09
        run_ticks(9, 1'b0);
        repeat (DIV - 1) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        snap("lap_on_tick", 24'h000009, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        snap("lap_exit", 24'h000010, 1'b0, 1'b0, 1'b0);

        // Async reset while holding 00:12.34
        run_ticks(1224, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        snap("hold_1234", 24'h001234, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        lap = 1'b0;
        model_reset();
        snap("async_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Clear coincident with tick and lap rise while holding
        run_ticks(12, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        snap("hold_12", 24'h000012, 1'b1, 1'b0, 1'b0);
        repeat (DIV - 2) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        snap("clear_priority", 24'h000000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        snap("no_rise_after_clear", 24'h000000, 1'b0, 1'b0, 1'b0);

        // Preload 59:59.99, then wrap
        step(1'b0, 1'b0, 1'b0);
        #2;
        force dut.u_m1.value = 4'd5;
        force dut.u_m0.value = 4'd9;
        force dut.u_s1.value = 4'd5;
        force dut.u_s0.value = 4'd9;
        force dut.u_c1.value = 4'd9;
        force dut.u_c0.value = 4'd9;
        #1;
        release dut.u_m1.value;
        release dut.u_m0.value;
        release dut.u_s1.value;
        release dut.u_s0.value;
        release dut.u_c1.value;
        release dut.u_c0.value;
        m_time = 24'h595999;
        snap("preload", 24'h595999, 1'b0, 1'b0, 1'b0);
        run_ticks(1, 1'b0);
        snap("wrap", 24'h000000, 1'b0, 1'b1, 1'b1);
        run_ticks(1, 1'b0);
        snap("after_wrap", 24'h000001, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        snap("clear_ovf", 24'h000000, 1'b0, 1'b0, 1'b0);

        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("tick_queue_drained", tick_q.size(), 32'd0);
        check("snap_queue_drained", snap_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
